alu_src_scheduler: RTL
======================

Name: alu_src_scheduler

Overview:
- Round-robin scheduler that shares the 4-bit, 6-input ALU result selector between up to six requesters.
- Picks one requester and drives the 3-bit select of the 6:1 result mux.
- Waits a programmable settle time, captures the mux output into a register, and hands it downstream with a valid/ready handshake.
- Sits between the requester-side control logic and the output pins / next stage.

Parameters:
- N_SRC, 6, number of active requesters; legal 2..6. Select codes 6 and 7 are never driven.
- SETTLE_CYCLES, 1, wait cycles between select change and capture; legal 0..15.
- TIMEOUT_CYCLES, 15, cycles OUTPUT may wait for out_ready; legal 1..255; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  6  per-source request, level; bits at index >= N_SRC are ignored.
- mux_dout  input  4  result from the 6:1 result mux.
- sel  output  3  select to the 6:1 result mux (binary index of granted source).
- gnt  output  6  one-hot grant; high from grant until completion.
- done  output  6  one-hot, one-cycle pulse when the granted transaction completes.
- out_data  output  4  captured result.
- out_src  output  3  index of the source that produced out_data.
- out_valid  output  1  out_data/out_src valid.
- out_ready  input  1  downstream accepts.
- busy  output  1  high in any state other than IDLE.
- timeout  output  1  one-cycle pulse on dropped transaction (optional feature only).

Behaviour:
- Reset (async, rst=1): state IDLE, pointer=0, sel=0, gnt=0, done=0, out_data=0, out_src=0, out_valid=0, busy=0, timeout=0, cnt=0. Reset mid-transaction aborts it with no done pulse.
- FSM states: IDLE, SETTLE, OUTPUT.
- IDLE:
  - On an edge with any valid req bit, choose the first set bit searching upward from pointer, wrapping at N_SRC.
  - Register gnt (one-hot), sel and out_src to that index; cnt=SETTLE_CYCLES; go to SETTLE.
  - With no request, all outputs hold and done=0.
- SETTLE: if cnt==0, capture mux_dout into out_data, set out_valid=1, go to OUTPUT; else decrement cnt.
- Capture timing: for a req sampled on edge E0, out_valid rises after edge E0+SETTLE_CYCLES+1.
- OUTPUT: out_valid held, out_data and out_src stable. On an edge with out_ready=1:
  - out_valid=0, gnt=0, done[idx]=1 for exactly one cycle.
  - pointer=(idx+1) mod N_SRC; go to IDLE.
- sel holds its last value while IDLE; it does not return to 0.
- A requester deasserting req after grant does not cancel the transaction; it completes normally.
- Simultaneous requests: only one is granted. Others wait, and round-robin guarantees each is served within N_SRC transactions.
- A requester may hold req continuously. After done it is re-eligible, but lower priority than the others until the pointer wraps.
- Throughput: one transaction per SETTLE_CYCLES+3 cycles when out_ready is held high.
- out_ready in IDLE or SETTLE is ignored.

Optional Feature:
- Macro: ALU_SRC_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter runs in OUTPUT. After TIMEOUT_CYCLES consecutive cycles with out_ready=0, the transaction is dropped: out_valid=0, gnt=0, timeout=1 for one cycle, no done pulse.
  - Pointer advances as on normal completion; return to IDLE.
  - out_ready=1 on the same edge the count expires wins (normal completion).
- Undefined: OUTPUT waits indefinitely; the timeout port exists and is tied to 0.

Decomposition:
- Package alu_sched_pkg: state enum (IDLE, SETTLE, OUTPUT), SEL_W=3, DATA_W=4, MAX_SRC=6.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: req vector and pointer. Outputs: found flag and index. Reusable by other shared-resource controllers.

Test Plan:
- Reset defaults: assert rst mid-SETTLE with req=6'b000100 → all outputs zero immediately (async), no done pulse, first grant after release goes to index 2.
- Single request: req=6'b001000, SETTLE_CYCLES=1, mux_dout=4'hA, out_ready=1 → sel=3 after E0, out_valid after E0+2 with out_data=4'hA and out_src=3, done=6'b001000 pulse on the next edge.
- Round-robin fairness: req=6'b111111 held, out_ready=1 → grant order 0,1,2,3,4,5,0; each done pulse exactly one cycle.
- Backpressure: out_ready=0 for 10 cycles in OUTPUT → out_valid and out_data stable throughout, gnt held; single completion when out_ready rises.
- Ignored indices: N_SRC=4, req=6'b110000 → stays IDLE, busy=0; then req=6'b110001 → grant index 0 only.
- Timeout (ALU_SRC_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=3): out_ready=0 → timeout pulse after 3 cycles in OUTPUT, no done, pointer advanced. Same run with out_ready=1 on the expiry edge → done, no timeout.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and widths for the ALU result-select scheduler
package alu_sched_pkg;
  localparam int SEL_W = 3;
  localparam int DATA_W = 4;
  localparam int MAX_SRC = 6;
  typedef enum logic [1:0] {IDLE, SETTLE, OUTPUT} state_t;
endpackage

// File: rtl/alu_src_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or above ptr, wrapping at N
module rr_pick
  import alu_sched_pkg::*;
#(
  parameter int N = MAX_SRC
) (
  input  logic [MAX_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  logic [SEL_W:0] c;
  // scan downward in distance so the nearest candidate to ptr wins
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = {1'b0, ptr} + (SEL_W + 1)'(k);
      c = (c >= (SEL_W + 1)'(N)) ? c - (SEL_W + 1)'(N) : c;
      if (req[c[SEL_W-1:0]]) begin
        found = 1'b1;
        idx = c[SEL_W-1:0];
      end
    end
  end
endmodule

// File: rtl/alu_src_scheduler.sv
// alu_src_scheduler: round-robin owner of the 6:1 ALU result mux; optional drop-on-stall via ALU_SRC_SCHED_TIMEOUT_EN
module alu_src_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_SRC-1:0] req,
  input  logic [DATA_W-1:0]  mux_dout,
  output logic [SEL_W-1:0]   sel,
  output logic [MAX_SRC-1:0] gnt,
  output logic [MAX_SRC-1:0] done,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               timeout
);
  state_t state;
  logic found;
  logic [SEL_W-1:0] pick, ptr, nxt;
  logic [3:0] cnt;
  rr_pick #(.N(N_SRC)) u_pick (.req(req), .ptr(ptr), .found(found), .idx(pick));
  assign busy = state != IDLE;
  assign nxt = (out_src == SEL_W'(N_SRC - 1)) ? '0 : out_src + 1'b1;
`ifdef ALU_SRC_SCHED_TIMEOUT_EN
  logic [7:0] wcnt;
  logic to_q;
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif
  // grant, settle, capture and hand off one transaction at a time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      gnt <= '0;
      done <= '0;
      out_data <= '0;
      out_src <= '0;
      out_valid <= 1'b0;
      cnt <= '0;
`ifdef ALU_SRC_SCHED_TIMEOUT_EN
      wcnt <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef ALU_SRC_SCHED_TIMEOUT_EN
      to_q <= 1'b0;
`endif
      case (state)
        IDLE: if (found) begin
          gnt <= MAX_SRC'(1) << pick;
          sel <= pick;
          out_src <= pick;
          cnt <= 4'(SETTLE_CYCLES);
          state <= SETTLE;
        end
        SETTLE: if (cnt == '0) begin
          out_data <= mux_dout;
          out_valid <= 1'b1;
          state <= OUTPUT;
`ifdef ALU_SRC_SCHED_TIMEOUT_EN
          wcnt <= '0;
`endif
        end else begin
          cnt <= cnt - 1'b1;
        end
        OUTPUT: if (out_ready) begin
          out_valid <= 1'b0;
          gnt <= '0;
          done <= gnt;
          ptr <= nxt;
          state <= IDLE;
        end
`ifdef ALU_SRC_SCHED_TIMEOUT_EN
        else if (wcnt == 8'(TIMEOUT_CYCLES - 1)) begin
          out_valid <= 1'b0;
          gnt <= '0;
          to_q <= 1'b1;
          ptr <= nxt;
          state <= IDLE;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
